sc_io_poller: RTL and testbench

Memory-mapped bus initiator that drives the single-cycle computer's data-memory/IO port, not the CPU. It periodically reads the switch register, converts the 10-bit value to four decimal digits, and writes the seven-segment patterns and the LED mirror back through the same address/data/write-enable interface. It gives the board a live switch readout without a running program and serves as a self-checking exerciser for the IO decode path.

---
 rtl/sc_io_pkg.sv | 34 +++
 rtl/seg7_encode.sv | 26 ++
 rtl/sc_io_poller.sv | 162 ++++++++++++++++
 tb/tb_sc_io_poller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_io_pkg.sv
// rtl/sc_io_pkg.sv - shared address map, blank pattern, FSM states and BCD helper for the IO poller
package sc_io_pkg;

  localparam logic [31:0] ADDR_SW   = 32'hffff_ff00;
  localparam logic [31:0] ADDR_HEX0 = 32'hffff_ff20;
  localparam logic [31:0] ADDR_HEX1 = 32'hffff_ff30;
  localparam logic [31:0] ADDR_HEX2 = 32'hffff_ff40;
  localparam logic [31:0] ADDR_HEX3 = 32'hffff_ff50;
  localparam logic [31:0] ADDR_HEX4 = 32'hffff_ff60;
  localparam logic [31:0] ADDR_HEX5 = 32'hffff_ff70;
  localparam logic [31:0] ADDR_LED  = 32'hffff_ff80;

  localparam logic [6:0] SEG_BLANK = 7'h7f;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_CONV,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Double-dabble correction: any nibble of 5 or more gets 3 added before the shift.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - BCD digit to active-low seven-segment pattern, bit0 = segment a
module seg7_encode
  import sc_io_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sc_io_poller.sv
// rtl/sc_io_poller.sv - periodic switch poller: reads SW, converts to decimal, writes HEX0-5 and LED
module sc_io_poller
  import sc_io_pkg::*;
#(
  parameter int PERIOD = 1000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        enable,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic        we,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] poll_count
);

  localparam int TW = $clog2(PERIOD);
  localparam logic [TW-1:0] T_LAST = TW'(PERIOD - 1);

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [9:0]    sw, sw_n;
  logic [9:0]    shreg, shreg_n;
  logic [15:0]   bcd, bcd_n;
  logic [3:0]    cnt, cnt_n;
  logic [31:0]   addr_n, wdata_n;
  logic          we_n;
  logic [15:0]   poll_count_n;

  logic [15:0] bcd_adj, bcd_step, digit_src;
  logic [9:0]  shreg_step;
  logic [6:0]  seg [4];
  logic [2:0]  wr_idx;
  logic [31:0] wr_addr, wr_data;
  logic        wrap;

  assign bcd_adj    = dabble_adjust(bcd);
  assign bcd_step   = {bcd_adj[14:0], shreg[9]};
  assign shreg_step = {shreg[8:0], 1'b0};

  // The first write is registered on the last CONV edge, so it must see the final shift result.
  assign digit_src = (state == ST_CONV) ? bcd_step : bcd;

  for (genvar g = 0; g < 4; g++) begin : g_seg
    seg7_encode u_seg (
      .digit (digit_src[4*g +: 4]),
      .seg   (seg[g])
    );
  end

  assign wr_idx = (state == ST_WRITE) ? cnt[2:0] + 3'd1 : 3'd0;

  always_comb begin
    wr_addr = ADDR_HEX0;
    wr_data = '0;
    case (wr_idx)
      3'd0: begin wr_addr = ADDR_HEX0; wr_data = {25'b0, seg[0]}; end
      3'd1: begin wr_addr = ADDR_HEX1; wr_data = {25'b0, seg[1]}; end
      3'd2: begin wr_addr = ADDR_HEX2; wr_data = {25'b0, seg[2]}; end
      3'd3: begin wr_addr = ADDR_HEX3; wr_data = {25'b0, seg[3]}; end
      3'd4: begin wr_addr = ADDR_HEX4; wr_data = {25'b0, SEG_BLANK}; end
      3'd5: begin wr_addr = ADDR_HEX5; wr_data = {25'b0, SEG_BLANK}; end
      3'd6: begin wr_addr = ADDR_LED;  wr_data = {22'b0, sw}; end
      default: begin wr_addr = ADDR_HEX0; wr_data = '0; end
    endcase
  end

  // Timer free-runs whenever enabled; a wrap outside IDLE is simply lost.
  assign wrap    = enable && (timer == T_LAST);
  assign timer_n = (!enable || timer == T_LAST) ? '0 : timer + 1'b1;

  always_comb begin
    state_n      = state;
    sw_n         = sw;
    shreg_n      = shreg;
    bcd_n        = bcd;
    cnt_n        = cnt;
    addr_n       = '0;
    wdata_n      = '0;
    we_n         = 1'b0;
    poll_count_n = poll_count;
    case (state)
      ST_IDLE: begin
        if (wrap) begin
          state_n = ST_READ;
          addr_n  = ADDR_SW;
        end
      end
      ST_READ: state_n = ST_CAPTURE;
      ST_CAPTURE: begin
        sw_n    = rdata[9:0];
        shreg_n = rdata[9:0];
        bcd_n   = '0;
        cnt_n   = '0;
        state_n = ST_CONV;
      end
      ST_CONV: begin
        bcd_n   = bcd_step;
        shreg_n = shreg_step;
        cnt_n   = cnt + 4'd1;
        if (cnt == 4'd9) begin
          state_n = ST_WRITE;
          cnt_n   = '0;
          addr_n  = wr_addr;
          wdata_n = wr_data;
          we_n    = 1'b1;
        end
      end
      ST_WRITE: begin
        if (cnt == 4'd6) begin
          state_n = ST_DONE;
        end else begin
          cnt_n   = cnt + 4'd1;
          addr_n  = wr_addr;
          wdata_n = wr_data;
          we_n    = 1'b1;
        end
      end
      ST_DONE: begin
        poll_count_n = poll_count + 16'd1;
        state_n      = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      timer      <= '0;
      sw         <= '0;
      shreg      <= '0;
      bcd        <= '0;
      cnt        <= '0;
      addr       <= '0;
      wdata      <= '0;
      we         <= 1'b0;
      poll_count <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      sw         <= sw_n;
      shreg      <= shreg_n;
      bcd        <= bcd_n;
      cnt        <= cnt_n;
      addr       <= addr_n;
      wdata      <= wdata_n;
      we         <= we_n;
      poll_count <= poll_count_n;
    end
  end

  assign busy = (state == ST_READ) || (state == ST_CAPTURE) ||
                (state == ST_CONV) || (state == ST_WRITE);
  assign done = (state == ST_DONE);

  logic unused_ok;
  assign unused_ok = &{1'b0, rdata[31:10], bcd_adj[15]};

endmodule

// File: tb/tb_sc_io_poller.sv
// tb/tb_sc_io_poller.sv - directed scoreboard bench for sc_io_poller
module tb_sc_io_poller;
  import sc_io_pkg::*;

  localparam int PERIOD = 32;

  logic        clock = 1'b0;
  logic        resetn, enable;
  logic [31:0] addr, wdata, rdata;
  logic        we, busy, done;
  logic [15:0] poll_count;
  logic [9:0]  sw_val;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  logic [63:0] exp_q[$];

  sc_io_poller #(.PERIOD(PERIOD)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .enable     (enable),
    .addr       (addr),
    .wdata      (wdata),
    .we         (we),
    .rdata      (rdata),
    .busy       (busy),
    .done       (done),
    .poll_count (poll_count)
  );

  always #5 clock = ~clock;

  // Bus slave: read data appears one clock after the SW address, with junk in the upper bits.
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rdata <= (addr == ADDR_SW && !we) ? {22'h15a5a5, sw_val} : 32'h1234_5678;
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7f;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_poll(input logic [9:0] s);
    int v;
    v = int'(s);
    exp_q.push_back({ADDR_HEX0, 25'b0, seg_of(v % 10)});
    exp_q.push_back({ADDR_HEX1, 25'b0, seg_of((v / 10) % 10)});
    exp_q.push_back({ADDR_HEX2, 25'b0, seg_of((v / 100) % 10)});
    exp_q.push_back({ADDR_HEX3, 25'b0, seg_of(v / 1000)});
    exp_q.push_back({ADDR_HEX4, 32'h0000_007f});
    exp_q.push_back({ADDR_HEX5, 32'h0000_007f});
    exp_q.push_back({ADDR_LED, 22'b0, s});
  endtask

  task automatic pop_check_write();
    logic [63:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wr_addr", addr, e[63:32]);
      check("wr_data", wdata, e[31:0]);
    end else begin
      check("unexpected_write", {31'b0, we}, 32'd0);
    end
  endtask

  task automatic wait_read(output int n, output int at);
    logic found;
    found = 1'b0;
    n = 0;
    at = 0;
    for (int i = 0; i < 3 * PERIOD + 40; i++) begin
      @(negedge clock);
      n++;
      if (busy) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
    check("read_seen", {31'b0, found}, 32'd1);
    check("read_addr", addr, ADDR_SW);
    check("read_we", {31'b0, we}, 32'd0);
  endtask

  // Entered at the negedge of the READ cycle.
  task automatic run_poll(input logic [9:0] s, input logic [15:0] pc, input int drop_at);
    int nb;
    logic got_done;
    push_poll(s);
    nb = 1;
    got_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (i == drop_at) enable = 1'b0;
      if (busy) nb++;
      if (we) pop_check_write();
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    check("done_seen", {31'b0, got_done}, 32'd1);
    check("writes_left", exp_q.size(), 32'd0);
    check("busy_cycles", nb, 32'd19);
    @(negedge clock);
    check("done_width", {31'b0, done}, 32'd0);
    check("poll_count", {16'b0, poll_count}, {16'b0, pc});
  endtask

  initial begin
    int n, r1, r2, cnt, wrs;

    resetn = 1'b0;
    enable = 1'b0;
    sw_val = 10'd987;
    repeat (3) @(negedge clock);
    check("rst_addr", addr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_we", {31'b0, we}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_poll_count", {16'b0, poll_count}, 32'd0);

    resetn = 1'b1;
    @(negedge clock);
    enable = 1'b1;
    wait_read(n, r1);
    check("first_read_latency", n, PERIOD);
    run_poll(10'd987, 16'd1, -1);

    sw_val = 10'd1023;
    wait_read(n, r2);
    check("read_spacing", r2 - r1, PERIOD);
    run_poll(10'd1023, 16'd2, -1);

    sw_val = 10'd0;
    r1 = r2;
    wait_read(n, r2);
    check("read_spacing", r2 - r1, PERIOD);
    run_poll(10'd0, 16'd3, -1);

    // Drop enable in the first CONV cycle; the poll must still complete.
    sw_val = 10'd555;
    wait_read(n, r1);
    run_poll(10'd555, 16'd4, 1);
    cnt = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clock);
      if (busy || we) cnt++;
    end
    check("idle_after_drop", cnt, 32'd0);

    // Reset during the third write.
    enable = 1'b1;
    sw_val = 10'd42;
    wait_read(n, r1);
    push_poll(10'd42);
    wrs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (we) begin
        pop_check_write();
        wrs++;
        if (wrs == 3) break;
      end
    end
    check("writes_before_reset", wrs, 32'd3);
    resetn = 1'b0;
    @(negedge clock);
    check("mid_rst_we", {31'b0, we}, 32'd0);
    check("mid_rst_addr", addr, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_poll_count", {16'b0, poll_count}, 32'd0);
    exp_q.delete();
    enable = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clock);
      if (we) cnt++;
    end
    check("post_reset_writes", cnt, 32'd0);

    // poll_count wrap from 16'hffff.
    force dut.poll_count = 16'hffff;
    @(negedge clock);
    release dut.poll_count;
    @(negedge clock);
    check("preload_poll_count", {16'b0, poll_count}, 32'h0000_ffff);
    enable = 1'b1;
    sw_val = 10'd7;
    wait_read(n, r1);
    run_poll(10'd7, 16'h0000, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
